// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and helpers for the ALU issue controller.
//   alu_op_e   5-bit opcode set understood by the shared ALU
//   alu_ctl_t  ALU control fields (unit select, sub-op, invert/direction, mul half)
//   state_e    issue controller FSM states
//   decode_op  opcode -> control fields (reserved codes decode to all zeros)
//   op_is_reserved / op_is_arith  opcode classification helpers
package alu_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_DEC   = 5'd2,
    OP_INC   = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_PASSA = 5'd7,
    OP_NAND  = 5'd8,
    OP_NOR   = 5'd9,
    OP_XNOR  = 5'd10,
    OP_NOTA  = 5'd11,
    OP_MULLO = 5'd12,
    OP_MULHI = 5'd13,
    OP_MOV   = 5'd14,
    OP_SHL   = 5'd15,
    OP_SHR   = 5'd16
  } alu_op_e;

  typedef struct packed {
    logic [1:0] alu_sel;
    logic [1:0] s;
    logic       inv;
    logic [1:0] mul;
  } alu_ctl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [4:0] OP_LAST = 5'd16;

  function automatic alu_ctl_t decode_op(alu_op_e op);
    alu_ctl_t c;
    c = '0;
    case (op)
      OP_ADD:   c.s = 2'b00;
      OP_SUB:   c.s = 2'b01;
      OP_DEC:   c.s = 2'b10;
      OP_INC:   c.s = 2'b11;
      OP_AND:   begin c.alu_sel = 2'b01; c.s = 2'b00; end
      OP_OR:    begin c.alu_sel = 2'b01; c.s = 2'b01; end
      OP_XOR:   begin c.alu_sel = 2'b01; c.s = 2'b10; end
      OP_PASSA: begin c.alu_sel = 2'b01; c.s = 2'b11; end
      OP_NAND:  begin c.alu_sel = 2'b01; c.s = 2'b00; c.inv = 1'b1; end
      OP_NOR:   begin c.alu_sel = 2'b01; c.s = 2'b01; c.inv = 1'b1; end
      OP_XNOR:  begin c.alu_sel = 2'b01; c.s = 2'b10; c.inv = 1'b1; end
      OP_NOTA:  begin c.alu_sel = 2'b01; c.s = 2'b11; c.inv = 1'b1; end
      OP_MULLO: begin c.alu_sel = 2'b10; c.mul = 2'b01; end
      OP_MULHI: begin c.alu_sel = 2'b10; c.mul = 2'b10; end
      OP_MOV:   begin c.alu_sel = 2'b10; c.s = 2'b01; end
      OP_SHL:   c.alu_sel = 2'b11;
      OP_SHR:   begin c.alu_sel = 2'b11; c.inv = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_is_reserved(logic [4:0] op);
    return op > OP_LAST;
  endfunction

  // Only the adder ops produce a meaningful carry.
  function automatic logic op_is_arith(logic [4:0] op);
    return op <= 5'd3;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst  clock / asynchronous active-high reset
//   req[1:0]  request lines
//   en        grant window; no grant is issued while low
//   gnt[1:0]  one-hot grant, combinational from req/en
// last_grant resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Priority only moves when a grant is actually issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (gnt[0]) last_grant <= 1'b0;
    else if (gnt[1]) last_grant <= 1'b1;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: shares one combinational ALU between two requesters.
//   in0_* / in1_*   valid/ready operation inputs (op, a, b) from EX pipe / aux port
//   alu_a, alu_b    latched operands to the external ALU
//   alu_sel/s/inv/mul  decoded ALU control fields
//   alu_y, alu_cout ALU result inputs
//   res_*           registered result with valid/ready backpressure,
//                   requester id and reserved-opcode error flag
// Optional: define ALU_CTRL_STATS_EN to add saturating grant counters
//   gnt_cnt0 / gnt_cnt1 (CNT_W bits each).
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [4:0]   in0_op,
  input  logic [W-1:0] in0_a,
  input  logic [W-1:0] in0_b,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [4:0]   in1_op,
  input  logic [W-1:0] in1_a,
  input  logic [W-1:0] in1_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_sel,
  output logic [1:0]   alu_s,
  output logic         alu_inv,
  output logic [1:0]   alu_mul,
  input  logic [W-1:0] alu_y,
  input  logic         alu_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_y,
  output logic         res_cout,
  output logic         res_id,
  output logic         res_err
`ifdef ALU_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  state_e       state;
  logic         window;
  logic [1:0]   gnt;
  logic         accept;
  logic [4:0]   sel_op;
  logic [W-1:0] a_p0;
  logic [W-1:0] b_p0;
  alu_ctl_t     ctl_p0;
  logic         id_p0;
  logic         err_p0;
  logic         arith_p0;

  // A new operation can enter when idle, or when the held result is
  // being consumed this cycle.
  assign window = (state == IDLE) || ((state == HOLD) && res_ready);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({in1_valid, in0_valid}),
    .en  (window),
    .gnt (gnt)
  );

  assign in0_ready = gnt[0];
  assign in1_ready = gnt[1];
  assign accept    = |gnt;
  assign sel_op    = gnt[1] ? in1_op : in0_op;

  assign alu_a   = a_p0;
  assign alu_b   = b_p0;
  assign alu_sel = ctl_p0.alu_sel;
  assign alu_s   = ctl_p0.s;
  assign alu_inv = ctl_p0.inv;
  assign alu_mul = ctl_p0.mul;

  // Stage p0: operand/control latch at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0     <= '0;
      b_p0     <= '0;
      ctl_p0   <= '0;
      id_p0    <= 1'b0;
      err_p0   <= 1'b0;
      arith_p0 <= 1'b0;
    end else if (accept) begin
      a_p0     <= gnt[1] ? in1_a : in0_a;
      b_p0     <= gnt[1] ? in1_b : in0_b;
      ctl_p0   <= decode_op(alu_op_e'(sel_op));
      id_p0    <= gnt[1];
      err_p0   <= op_is_reserved(sel_op);
      arith_p0 <= op_is_arith(sel_op);
    end
  end

  // Stage p1: result capture and hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          res_y     <= err_p0 ? '0 : alu_y;
          res_cout  <= arith_p0 & alu_cout;
          res_id    <= id_p0;
          res_err   <= err_p0;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CTRL_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt[0]) gnt_cnt0 <= sat_inc(gnt_cnt0);
      if (gnt[1]) gnt_cnt1 <= sat_inc(gnt_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: self-checking bench for alu_issue_ctrl with a behavioural
// ALU attached and an opcode-level reference model plus result queue.
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W     = 16;
  localparam int CNT_W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in0_valid = 1'b0, in1_valid = 1'b0;
  logic         in0_ready, in1_ready;
  logic [4:0]   in0_op = '0, in1_op = '0;
  logic [W-1:0] in0_a = '0, in0_b = '0, in1_a = '0, in1_b = '0;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [1:0]   alu_sel, alu_s, alu_mul;
  logic         alu_inv, alu_cout;
  logic         res_valid, res_cout, res_id, res_err;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_y;
`ifdef ALU_CTRL_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         id;
    logic         e;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_op(in0_op), .in0_a(in0_a), .in0_b(in0_b),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_op(in1_op), .in1_a(in1_a), .in1_b(in1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_s(alu_s), .alu_inv(alu_inv),
    .alu_mul(alu_mul), .alu_y(alu_y), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_cout(res_cout),
    .res_id(res_id), .res_err(res_err)
`ifdef ALU_CTRL_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // Behavioural ALU driven by the control fields.
  logic [W:0]     alu_sum;
  logic [2*W-1:0] alu_prod;
  logic [W-1:0]   alu_lg;
  always_comb begin
    alu_sum  = '0;
    alu_lg   = '0;
    alu_prod = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};
    alu_y    = '0;
    alu_cout = 1'b0;
    case (alu_sel)
      2'b00: begin
        case (alu_s)
          2'b00:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
          2'b01:   alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
          2'b10:   alu_sum = {1'b0, alu_a} + {1'b0, {W{1'b1}}};
          default: alu_sum = {1'b0, alu_a} + 17'd1;
        endcase
        alu_y    = alu_sum[W-1:0];
        alu_cout = alu_sum[W];
      end
      2'b01: begin
        case (alu_s)
          2'b00:   alu_lg = alu_a & alu_b;
          2'b01:   alu_lg = alu_a | alu_b;
          2'b10:   alu_lg = alu_a ^ alu_b;
          default: alu_lg = alu_a;
        endcase
        alu_y = alu_inv ? ~alu_lg : alu_lg;
      end
      2'b10: begin
        if (alu_mul == 2'b01)      alu_y = alu_prod[W-1:0];
        else if (alu_mul == 2'b10) alu_y = alu_prod[2*W-1:W];
        else if (alu_s == 2'b01)   alu_y = alu_b;
      end
      default: alu_y = alu_inv ? (alu_a >> alu_b[3:0]) : (alu_a << alu_b[3:0]);
    endcase
  end

  // Opcode-level reference: what each operation means arithmetically.
  function automatic exp_t model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic id);
    exp_t e;
    int unsigned ua, ub, r;
    ua = a; ub = b;
    e = '0;
    e.id = id;
    case (op)
      0:  begin r = ua + ub; e.y = 16'(r); e.c = (r > 32'hFFFF); end
      1:  begin e.y = 16'(ua - ub); e.c = (ua >= ub); end
      2:  begin e.y = 16'(ua - 1); e.c = (ua != 0); end
      3:  begin e.y = 16'(ua + 1); e.c = (ua == 32'hFFFF); end
      4:  e.y = a & b;
      5:  e.y = a | b;
      6:  e.y = a ^ b;
      7:  e.y = a;
      8:  e.y = ~(a & b);
      9:  e.y = ~(a | b);
      10: e.y = ~(a ^ b);
      11: e.y = ~a;
      12: begin r = ua * ub; e.y = 16'(r); end
      13: begin r = ua * ub; e.y = 16'(r >> 16); end
      14: e.y = b;
      15: e.y = 16'(ua << (ub % 16));
      16: e.y = 16'(ua >> (ub % 16));
      default: e.e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [4:0] rand_op();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(17, 31));
    return 5'($urandom_range(0, 16));
  endfunction

  task automatic do_reset();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one op on requester r until it is accepted; returns just after the accept edge.
  task automatic issue_one(input int r, input logic [4:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    if (r == 0) begin in0_valid = 1'b1; in0_op = op; in0_a = a; in0_b = b; end
    else        begin in1_valid = 1'b1; in1_op = op; in1_a = a; in1_b = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (r == 0) ? in0_ready : in1_ready;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL issue_timeout req=%0d: ready never seen, required 1", r);
    end
    @(posedge clk);
    #1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({res_valid, in0_ready, in1_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_handshake: got %b, required 000", {res_valid, in0_ready, in1_ready});
    end
    checks++;
    if ({alu_a, alu_b, alu_sel, alu_s, alu_inv, alu_mul} !== '0) begin
      failures++;
      $display("FAIL reset_alu: got a=%h b=%h sel=%b s=%b inv=%b mul=%b, required all 0",
               alu_a, alu_b, alu_sel, alu_s, alu_inv, alu_mul);
    end
    checks++;
    if ({res_y, res_cout, res_id, res_err} !== '0) begin
      failures++;
      $display("FAIL reset_res: got y=%h c=%b id=%b err=%b, required all 0",
               res_y, res_cout, res_id, res_err);
    end
  endtask

  task automatic test_add();
    res_ready = 1'b1;
    issue_one(0, 5'd0, 16'h0003, 16'h0004);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_latency: res_valid=%b one edge after accept, required 0", res_valid);
    end
    @(negedge clk);
    checks++;
    if ({res_valid, res_y, res_cout, res_id, res_err} !== {1'b1, 16'h0007, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add_result: got v=%b y=%h c=%b id=%b err=%b, required v=1 y=0007 c=0 id=0 err=0",
               res_valid, res_y, res_cout, res_id, res_err);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_consume: res_valid=%b after consume, required 0", res_valid);
    end
  endtask

  task automatic test_add_carry();
    res_ready = 1'b1;
    issue_one(0, 5'd0, 16'hFFFF, 16'h0001);
    repeat (2) @(negedge clk);
    checks++;
    if ({res_valid, res_y, res_cout} !== {1'b1, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL add_carry: got v=%b y=%h c=%b, required v=1 y=0000 c=1",
               res_valid, res_y, res_cout);
    end
  endtask

  task automatic test_shr();
    res_ready = 1'b1;
    issue_one(1, 5'd16, 16'h8000, 16'h0004);
    repeat (2) @(negedge clk);
    checks++;
    if ({res_valid, res_y, res_cout, res_id} !== {1'b1, 16'h0800, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL shr: got v=%b y=%h c=%b id=%b, required v=1 y=0800 c=0 id=1",
               res_valid, res_y, res_cout, res_id);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int nres, nacc;
    bit a0, a1;
    q.delete();
    do_reset();
    nres = 0; nacc = 0;
    res_ready = 1'b1;
    in0_op = 5'($urandom_range(0, 16)); in0_a = 16'($urandom); in0_b = 16'($urandom);
    in1_op = 5'($urandom_range(0, 16)); in1_a = 16'($urandom); in1_b = 16'($urandom);
    in0_valid = 1'b1; in1_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && nres < 6; cyc++) begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected: result y=%h with nothing issued", res_y);
        end else begin
          e = q.pop_front();
          if ({res_y, res_cout, res_id, res_err} !== {e.y, e.c, e.id, e.e} || res_id !== 1'(nres % 2)) begin
            failures++;
            $display("FAIL b2b_result#%0d: got y=%h c=%b id=%b err=%b, required y=%h c=%b id=%0d err=%b",
                     nres, res_y, res_cout, res_id, res_err, e.y, e.c, nres % 2, e.e);
          end
        end
        nres++;
      end
      checks++;
      if (in0_ready && in1_ready) begin
        failures++;
        $display("FAIL b2b_both_ready: got 11, required at most one");
      end
      a0 = in0_ready; a1 = in1_ready;
      if (a0) begin q.push_back(model(in0_op, in0_a, in0_b, 1'b0)); nacc++; end
      if (a1) begin q.push_back(model(in1_op, in1_a, in1_b, 1'b1)); nacc++; end
      @(posedge clk);
      #1;
      if (a0) begin in0_op = 5'($urandom_range(0, 16)); in0_a = 16'($urandom); in0_b = 16'($urandom); end
      if (a1) begin in1_op = 5'($urandom_range(0, 16)); in1_a = 16'($urandom); in1_b = 16'($urandom); end
      if (nacc >= 6) begin in0_valid = 1'b0; in1_valid = 1'b0; end
    end
    checks++;
    if (nres != 6) begin
      failures++;
      $display("FAIL b2b_count: got %0d results, required 6", nres);
    end
  endtask

  task automatic test_backpressure();
    exp_t e0, e1;
    logic [W-1:0] held;
    res_ready = 1'b0;
    e0 = model(6, 16'h5A5A, 16'h0FF0, 1'b0);
    issue_one(0, 5'd6, 16'h5A5A, 16'h0FF0);
    for (int i = 0; i < 5 && res_valid !== 1'b1; i++) @(negedge clk);
    held = res_y;
    checks++;
    if ({res_valid, res_y, res_id} !== {1'b1, e0.y, 1'b0}) begin
      failures++;
      $display("FAIL bp_first: got v=%b y=%h id=%b, required v=1 y=%h id=0", res_valid, res_y, res_id, e0.y);
    end
    in0_valid = 1'b1; in0_op = 5'd1; in0_a = 16'h1234; in0_b = 16'h0034;
    in1_valid = 1'b1; in1_op = 5'd12; in1_a = 16'h0100; in1_b = 16'h0203;
    e1 = model(12, 16'h0100, 16'h0203, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_y, in0_ready, in1_ready} !== {1'b1, held, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: got v=%b y=%h rdy=%b%b, required v=1 y=%h rdy=00",
                 i, res_valid, res_y, in1_ready, in0_ready, held);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if ({in1_ready, in0_ready} !== 2'b10) begin
      failures++;
      $display("FAIL bp_resume_grant: got rdy1,rdy0=%b%b, required 10", in1_ready, in0_ready);
    end
    @(posedge clk);
    #1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({res_valid, res_y, res_id} !== {1'b1, e1.y, 1'b1}) begin
      failures++;
      $display("FAIL bp_resume_result: got v=%b y=%h id=%b, required v=1 y=%h id=1",
               res_valid, res_y, res_id, e1.y);
    end
  endtask

  task automatic test_reserved();
    res_ready = 1'b1;
    issue_one(0, 5'd20, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    checks++;
    if ({alu_sel, alu_s, alu_inv, alu_mul} !== 7'b0) begin
      failures++;
      $display("FAIL reserved_ctl: got sel=%b s=%b inv=%b mul=%b, required all 0",
               alu_sel, alu_s, alu_inv, alu_mul);
    end
    @(negedge clk);
    checks++;
    if ({res_valid, res_err, res_y, res_cout} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL reserved_result: got v=%b err=%b y=%h c=%b, required v=1 err=1 y=0000 c=0",
               res_valid, res_err, res_y, res_cout);
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    issue_one(0, 5'd0, 16'h0001, 16'h0002);
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_discard cycle %0d: res_valid=%b, required 0", i, res_valid);
      end
    end
    issue_one(1, 5'd3, 16'hFFFF, 16'h0000);
    repeat (2) @(negedge clk);
    checks++;
    if ({res_valid, res_y, res_cout, res_id} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_next: got v=%b y=%h c=%b id=%b, required v=1 y=0000 c=1 id=1",
               res_valid, res_y, res_cout, res_id);
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit a0, a1;
    q.delete();
    do_reset();
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected: result y=%h with nothing issued", res_y);
        end else begin
          e = q.pop_front();
          if ({res_y, res_cout, res_id, res_err} !== {e.y, e.c, e.id, e.e}) begin
            failures++;
            $display("FAIL rand_result cyc %0d: got y=%h c=%b id=%b err=%b, required y=%h c=%b id=%b err=%b",
                     cyc, res_y, res_cout, res_id, res_err, e.y, e.c, e.id, e.e);
          end
        end
      end
      checks++;
      if (in0_ready && in1_ready) begin
        failures++;
        $display("FAIL rand_both_ready: got 11, required at most one");
      end
      a0 = in0_ready; a1 = in1_ready;
      if (a0) q.push_back(model(in0_op, in0_a, in0_b, 1'b0));
      if (a1) q.push_back(model(in1_op, in1_a, in1_b, 1'b1));
      @(posedge clk);
      #1;
      if (a0 || !in0_valid) begin
        in0_valid = 1'($urandom_range(0, 1)); in0_op = rand_op();
        in0_a = 16'($urandom); in0_b = 16'($urandom);
      end
      if (a1 || !in1_valid) begin
        in1_valid = 1'($urandom_range(0, 1)); in1_op = rand_op();
        in1_a = 16'($urandom); in1_b = 16'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      if (cyc >= 300) begin in0_valid = 1'b0; in1_valid = 1'b0; res_ready = 1'b1; end
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rand_drain: %0d results outstanding, required 0", q.size());
    end
  endtask

`ifdef ALU_CTRL_STATS_EN
  task automatic test_stats();
    int n;
    do_reset();
    res_ready = 1'b1;
    n = 0;
    in0_valid = 1'b1; in0_op = 5'd0; in0_a = 16'h0001; in0_b = 16'h0001;
    for (int cyc = 0; cyc < 200 && n < (1 << CNT_W) + 3; cyc++) begin
      @(negedge clk);
      if (in0_ready) n++;
      @(posedge clk);
      #1;
      if (n >= (1 << CNT_W) + 3) in0_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({gnt_cnt0, gnt_cnt1} !== {{CNT_W{1'b1}}, {CNT_W{1'b0}}}) begin
      failures++;
      $display("FAIL stats_saturate: got cnt0=%h cnt1=%h after %0d grants, required cnt0=%h cnt1=0",
               gnt_cnt0, gnt_cnt1, n, {CNT_W{1'b1}});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_add_carry();
    test_shr();
    test_back_to_back();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_random();
`ifdef ALU_CTRL_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
